// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/execute program counter sequencer with return-address stack
// Computes the next PC per instruction from the decoded control op and holds call return addresses.
module pc_sequencer #(
  parameter int WIDTH = 8,
  parameter int STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic             cond,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             mem_rd,
  output logic             halted,
  output logic             stack_err
);
  localparam int AW = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;

  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;
  localparam logic [2:0] OP_HALT   = 3'd5;

  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [SPW-1:0]     sp;
  logic [WIDTH-1:0]   stack [STACK_DEPTH];
  logic [WIDTH-1:0]   pc_inc;
  logic [WIDTH-1:0]   stack_top;
  logic               update, full, empty;
  logic               push, pop, err_set;

  assign pc_inc    = pc + WIDTH'(1);
  assign full      = (sp == SPW'(STACK_DEPTH));
  assign empty     = (sp == '0);
  assign stack_top = stack[AW'(sp - SPW'(1))];
  assign update    = (state == EXEC) && op_valid && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_VEC;
      sp        <= '0;
      stack_err <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_next;
      if (push) sp <= sp + SPW'(1);
      else if (pop) sp <= sp - SPW'(1);
      if (err_set) stack_err <= 1'b1;
    end
  end

  // Stack contents need no reset: only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (push) stack[sp[AW-1:0]] <= pc_inc;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: if (!stall) state_nxt = EXEC;
      EXEC: begin
        if (update) begin
          if ((op == OP_HALT) || (op == OP_CALL && full) || (op == OP_RET && empty))
            state_nxt = HALT;
          else
            state_nxt = FETCH;
        end
      end
      default: state_nxt = HALT;
    endcase
  end

  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    mem_rd  = (state == FETCH) && !stall;
    halted  = (state == HALT);
    if (update) begin
      case (op)
        OP_JUMP:   pc_next = target;
        OP_BRANCH: pc_next = cond ? target : pc_inc;
        OP_CALL: begin
          if (full) err_set = 1'b1;
          else begin
            push    = 1'b1;
            pc_next = target;
          end
        end
        OP_RET: begin
          if (empty) err_set = 1'b1;
          else begin
            pop     = 1'b1;
            pc_next = stack_top;
          end
        end
        OP_HALT:   pc_next = pc;
        default:   pc_next = pc_inc;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed scoreboard bench for pc_sequencer
// Expected PCs come from a behavioural model and are queued at issue, compared after the update edge.
module tb_pc_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       stall = 1'b0;
  logic       op_valid = 1'b0;
  logic [2:0] op = 3'd0;
  logic       cond = 1'b0;
  logic [7:0] target = 8'd0;
  logic [7:0] pc, pc_next;
  logic       mem_rd, halted, stack_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_err, m_halt;
  logic [7:0] exp_q[$];

  pc_sequencer #(.WIDTH(8), .STACK_DEPTH(4), .RESET_VEC(8'h00)) dut (
    .clk(clk), .reset(reset), .stall(stall), .op_valid(op_valid), .op(op),
    .cond(cond), .target(target), .pc(pc), .pc_next(pc_next), .mem_rd(mem_rd),
    .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    op_valid = 1'b0;
    m_pc = 8'h00; m_stk.delete(); m_err = 1'b0; m_halt = 1'b0;
    #1;
    chk("rst_pc", pc, m_pc);
    chk("rst_err", stack_err, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One instruction: FETCH (with fstall stall cycles) then EXEC (with estall stall cycles).
  task automatic do_instr(input logic [2:0] o, input logic c, input logic [7:0] t,
                          input int fstall, input int estall);
    logic [7:0] e;
    op_valid = 1'b0;
    stall = (fstall > 0);
    for (int i = 0; i < fstall; i++) begin
      #1;
      chk("fstall_mem_rd", mem_rd, 1'b0);
      chk("fstall_pc", pc, m_pc);
      @(negedge clk);
    end
    stall = 1'b0;
    #1;
    chk("fetch_mem_rd", mem_rd, !m_halt);
    @(negedge clk);
    op = o; cond = c; target = t; op_valid = 1'b1;
    stall = (estall > 0);
    for (int i = 0; i < estall; i++) begin
      #1;
      chk("estall_pc_next", pc_next, m_pc);
      @(negedge clk);
      chk("estall_pc", pc, m_pc);
    end
    stall = 1'b0;
    if (m_halt) e = m_pc;
    else begin
      case (o)
        3'd1: e = t;
        3'd2: e = c ? t : m_pc + 8'd1;
        3'd3: begin
          if (m_stk.size() == 4) begin m_err = 1'b1; m_halt = 1'b1; e = m_pc; end
          else begin m_stk.push_back(m_pc + 8'd1); e = t; end
        end
        3'd4: begin
          if (m_stk.size() == 0) begin m_err = 1'b1; m_halt = 1'b1; e = m_pc; end
          else e = m_stk.pop_back();
        end
        3'd5: begin m_halt = 1'b1; e = m_pc; end
        default: e = m_pc + 8'd1;
      endcase
    end
    exp_q.push_back(e);
    #1;
    chk("exec_mem_rd", mem_rd, 1'b0);
    chk("pc_next", pc_next, e);
    @(posedge clk);
    #1;
    m_pc = exp_q.pop_front();
    chk("pc", pc, m_pc);
    chk("stack_err", stack_err, m_err);
    chk("halted", halted, m_halt);
    op_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    // Sequential fetch/execute: 0 -> 1 -> 2 -> 3
    for (int i = 0; i < 3; i++) do_instr(3'd0, 1'b0, 8'h00, 0, 0);
    do_instr(3'd7, 1'b0, 8'hAA, 0, 0);
    // Wrap at the top address
    do_instr(3'd1, 1'b0, 8'hFF, 0, 0);
    do_instr(3'd0, 1'b0, 8'h00, 0, 0);
    // Branch not taken / taken
    do_instr(3'd1, 1'b0, 8'h10, 0, 0);
    do_instr(3'd2, 1'b0, 8'h40, 0, 0);
    do_instr(3'd1, 1'b0, 8'h10, 0, 0);
    do_instr(3'd2, 1'b1, 8'h40, 0, 0);
    // Call / return, then confirm stack is empty via underflow
    do_instr(3'd1, 1'b0, 8'h05, 0, 0);
    do_instr(3'd3, 1'b0, 8'h80, 0, 0);
    do_instr(3'd4, 1'b0, 8'h00, 0, 0);
    do_instr(3'd4, 1'b0, 8'h00, 0, 0);
    do_reset();
    // CALL from the top address pushes 0
    do_instr(3'd1, 1'b0, 8'hFF, 0, 0);
    do_instr(3'd3, 1'b0, 8'h30, 0, 0);
    do_instr(3'd4, 1'b0, 8'h00, 0, 0);
    do_reset();
    // Nested calls to overflow, then ignored ops
    do_instr(3'd3, 1'b0, 8'h20, 0, 0);
    do_instr(3'd3, 1'b0, 8'h40, 0, 0);
    do_instr(3'd3, 1'b0, 8'h60, 0, 0);
    do_instr(3'd3, 1'b0, 8'h80, 0, 0);
    do_instr(3'd3, 1'b0, 8'hA0, 0, 0);
    do_instr(3'd0, 1'b0, 8'h00, 0, 0);
    do_instr(3'd1, 1'b0, 8'h77, 0, 0);
    do_reset();
    // Underflow at 0x22
    do_instr(3'd1, 1'b0, 8'h22, 0, 0);
    do_instr(3'd4, 1'b0, 8'h00, 0, 0);
    do_reset();
    // Explicit HALT op
    do_instr(3'd5, 1'b0, 8'h00, 0, 0);
    do_instr(3'd0, 1'b0, 8'h00, 0, 0);
    do_reset();
    // Stalls in FETCH and EXEC
    do_instr(3'd1, 1'b0, 8'h33, 3, 2);
    do_instr(3'd2, 1'b1, 8'h90, 1, 1);
    // Asynchronous reset mid-EXEC
    op_valid = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    op = 3'd1; target = 8'h55; op_valid = 1'b1; stall = 1'b1;
    #1;
    chk("midexec_mem_rd", mem_rd, 1'b0);
    reset = 1'b1;
    #1;
    chk("midexec_rst_pc", pc, 8'h00);
    chk("midexec_rst_halted", halted, 1'b0);
    stall = 1'b0;
    op_valid = 1'b0;
    #1;
    chk("midexec_rst_fetch", mem_rd, 1'b1);
    m_pc = 8'h00; m_stk.delete(); m_err = 1'b0; m_halt = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_instr(3'd0, 1'b0, 8'h00, 0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Control block that sequences the 8-bit program counter register of the processor core. It runs a fetch/execute state machine and, each instruction, computes the next PC from the decoded control op: sequential, jump, conditional branch, call or return. A small internal return-address stack supports call and return. The pc_next output feeds the PC register data input; pc mirrors the register's contents.

Parameters:
WIDTH, 8, PC / address width in bits
STACK_DEPTH, 4, number of return-address stack entries (power of 2, >=2)
RESET_VEC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state
stall  input  1  freezes FSM and PC while high
op_valid  input  1  decoded op/cond/target valid in EXEC
op  input  3  0=NEXT 1=JUMP 2=BRANCH 3=CALL 4=RET 5=HALT; 6,7 treated as NEXT
cond  input  1  branch condition, sampled only for BRANCH
target  input  WIDTH  jump/branch/call destination
pc  output  WIDTH  registered current PC
pc_next  output  WIDTH  combinational value pc takes at next posedge (equals pc when not updating)
mem_rd  output  1  instruction fetch strobe, high in FETCH when not stalled
halted  output  1  high in HALT state
stack_err  output  1  sticky; set on stack overflow or underflow

Behaviour:
- Reset (async, any state, mid-operation included): pc=RESET_VEC, state=FETCH, stack pointer=0 (empty), stack_err=0, halted=0. mem_rd follows state/stall combinationally, so it is 1 during reset unless stall=1.
- States: FETCH, EXEC, HALT.
- FETCH: mem_rd=1 unless stall. With stall=0, go to EXEC next cycle; with stall=1, stay. pc unchanged.
- EXEC: mem_rd=0. Update only when op_valid=1 and stall=0; otherwise hold state and pc. On update, pc<=computed value and state<=FETCH, except where noted below.
- Next-PC rules, all arithmetic mod 2^WIDTH:
  - NEXT: pc+1.
  - JUMP: target.
  - BRANCH: target if cond=1, else pc+1.
  - CALL: push pc+1 and set pc=target.
  - RET: pop and set pc to the popped value.
  - HALT: pc unchanged, state<=HALT.
- Wrap-around: pc=2^WIDTH-1 with NEXT or not-taken BRANCH gives 0. CALL from the top address pushes 0.
- Stack overflow (CALL when STACK_DEPTH entries are held): no push, pc unchanged, stack_err<=1, state<=HALT.
- Stack underflow (RET when empty): pc unchanged, stack_err<=1, state<=HALT.
- HALT: pc frozen, halted=1, mem_rd=0, inputs ignored. Only reset exits HALT.
- pc_next always equals the value pc will hold after the next posedge, given the current inputs.
- Latency: 2 cycles per instruction with no stalls (FETCH then EXEC). A stall adds cycles 1:1.
- op, cond and target are ignored outside EXEC and when op_valid=0.

Test Plan:
- Reset with RESET_VEC=0, then NEXT ops with op_valid=1 and stall=0 → pc goes 0,1,2,3 with updates every 2 cycles; mem_rd=1 in alternate cycles.
- pc=8'hFF, NEXT → pc=8'h00, no error. Separately, pc=8'h10, BRANCH target=8'h40: cond=0 gives 8'h11, cond=1 gives 8'h40.
- pc=8'h05, CALL target=8'h80, then at 8'h80 RET → pc sequence 05→80→06; stack empty afterwards; stack_err=0.
- 4 nested CALLs followed by a 5th CALL → after the 5th, pc unchanged, stack_err=1, halted=1; subsequent ops are ignored until reset.
- RET on an empty stack at pc=8'h22 → pc stays 8'h22, stack_err=1, halted=1. Assert reset → pc=0, stack_err=0, halted=0.
- stall held 3 cycles in FETCH and 2 cycles in EXEC → pc and state are held during the stall, mem_rd=0 while stalled, and the update completes on the first unstalled EXEC cycle. Assert reset mid-EXEC → immediate pc=RESET_VEC and state FETCH.
